// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Walks a classifier cascade one stage at a time for a single window. For
//   each stage it fetches the stage threshold from an external ROM, asks the
//   feature engine to evaluate the stage, accumulates the signed votes it
//   returns (saturating), and compares the sum against the threshold. The
//   first failing stage ends the window with detect=0. Passing every stage
//   ends it with detect=1.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active-low
//   start        : begin one window (only honoured while idle)
//   busy         : high whenever the sequencer is not idle
//   thr_en       : threshold ROM read enable
//   thr_addr     : threshold ROM address
//   thr_data     : ROM read data, valid the cycle after thr_en
//   stage_idx    : current stage, for the feature engine
//   stage_go     : one-cycle pulse, evaluate stage stage_idx
//   feat_valid   : feature vote valid
//   feat_val     : signed feature vote
//   feat_last    : qualifies feat_valid, last vote of the stage
//   done         : one-cycle pulse, result valid
//   detect       : 1 = window passed all stages
//   reject_stage : failing stage index when detect=0
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int W_DATA   = 11,
  parameter int W_ADDR   = 5,
  parameter int N_STAGES = 25,
  parameter int W_SUM    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              thr_en,
  output logic [W_ADDR-1:0] thr_addr,
  input  logic [W_DATA-1:0] thr_data,
  output logic [W_ADDR-1:0] stage_idx,
  output logic              stage_go,
  input  logic              feat_valid,
  input  logic [W_SUM-1:0]  feat_val,
  input  logic              feat_last,
  output logic              done,
  output logic              detect,
  output logic [W_ADDR-1:0] reject_stage
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [W_ADDR-1:0] LAST_STAGE = W_ADDR'(N_STAGES - 1);
  localparam logic [W_SUM-1:0]  SUM_MAX    = {1'b0, {(W_SUM-1){1'b1}}};
  localparam logic [W_SUM-1:0]  SUM_MIN    = {1'b1, {(W_SUM-1){1'b0}}};

  // Two's complement add clamped to the accumulator range. Overflow is
  // detected by the two top bits of a one-bit-wider sum disagreeing.
  function automatic logic [W_SUM-1:0] sat_add(input logic [W_SUM-1:0] a,
                                               input logic [W_SUM-1:0] b);
    logic [W_SUM:0] wide;
    logic [W_SUM-1:0] res;
    wide = {a[W_SUM-1], a} + {b[W_SUM-1], b};
    if (wide[W_SUM] != wide[W_SUM-1]) begin
      res = wide[W_SUM] ? SUM_MIN : SUM_MAX;
    end else begin
      res = wide[W_SUM-1:0];
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [W_ADDR-1:0] stage_idx_q, stage_idx_d;
  logic [W_SUM-1:0]  acc_q, acc_d;
  logic [W_SUM-1:0]  thr_q, thr_d;
  logic              detect_q, detect_d;
  logic [W_ADDR-1:0] reject_stage_q, reject_stage_d;
  logic              busy_q, busy_d;
  logic              thr_en_q, thr_en_d;
  logic [W_ADDR-1:0] thr_addr_q, thr_addr_d;
  logic              stage_go_q, stage_go_d;
  logic              done_q, done_d;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d        = state_q;
    stage_idx_d    = stage_idx_q;
    acc_d          = acc_q;
    thr_d          = thr_q;
    detect_d       = detect_q;
    reject_stage_d = reject_stage_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          stage_idx_d = {W_ADDR{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        thr_d   = W_SUM'($signed(thr_data));
        acc_d   = {W_SUM{1'b0}};
        state_d = RUN;
      end
      RUN: begin
        if (feat_valid) begin
          acc_d = sat_add(acc_q, feat_val);
          if (feat_last) begin
            state_d = CMP;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      CMP: begin
        if ($signed(acc_q) < $signed(thr_q)) begin
          detect_d       = 1'b0;
          reject_stage_d = stage_idx_q;
          state_d        = DONE;
        end else if (stage_idx_q == LAST_STAGE) begin
          detect_d       = 1'b1;
          reject_stage_d = {W_ADDR{1'b0}};
          state_d        = DONE;
        end else begin
          stage_idx_d = stage_idx_q + W_ADDR'(1);
          state_d     = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so their flops line up with
    // the state they describe.
    busy_d     = (state_d != IDLE);
    thr_en_d   = (state_d == FETCH);
    stage_go_d = (state_d == LOAD);
    done_d     = (state_d == DONE);
    if (state_d == FETCH) begin
      thr_addr_d = stage_idx_d;
    end else begin
      thr_addr_d = thr_addr_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      stage_idx_q    <= {W_ADDR{1'b0}};
      acc_q          <= {W_SUM{1'b0}};
      thr_q          <= {W_SUM{1'b0}};
      detect_q       <= 1'b0;
      reject_stage_q <= {W_ADDR{1'b0}};
      busy_q         <= 1'b0;
      thr_en_q       <= 1'b0;
      thr_addr_q     <= {W_ADDR{1'b0}};
      stage_go_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_idx_q    <= stage_idx_d;
      acc_q          <= acc_d;
      thr_q          <= thr_d;
      detect_q       <= detect_d;
      reject_stage_q <= reject_stage_d;
      busy_q         <= busy_d;
      thr_en_q       <= thr_en_d;
      thr_addr_q     <= thr_addr_d;
      stage_go_q     <= stage_go_d;
      done_q         <= done_d;
    end
  end

  assign busy         = busy_q;
  assign thr_en       = thr_en_q;
  assign thr_addr     = thr_addr_q;
  assign stage_idx    = stage_idx_q;
  assign stage_go     = stage_go_q;
  assign done         = done_q;
  assign detect       = detect_q;
  assign reject_stage = reject_stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//   Self-checking bench for stage_sequencer. A threshold ROM and a feature
//   engine are modelled around the DUT. Each window's vote plan is scored by a
//   reference model (plain integer sums with clamping) and the expected result
//   is queued; a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int W_DATA   = 11;
  localparam int W_ADDR   = 5;
  localparam int N_STAGES = 25;
  localparam int W_SUM    = 16;
  localparam int MAXV     = 4;
  localparam int SMAX     = 32767;
  localparam int SMIN     = -32768;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              thr_en;
  logic [W_ADDR-1:0] thr_addr;
  logic [W_DATA-1:0] thr_data = '0;
  logic [W_ADDR-1:0] stage_idx;
  logic              stage_go;
  logic              feat_valid;
  logic [W_SUM-1:0]  feat_val;
  logic              feat_last;
  logic              done;
  logic              detect;
  logic [W_ADDR-1:0] reject_stage;

  stage_sequencer #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_STAGES(N_STAGES), .W_SUM(W_SUM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .thr_en(thr_en),
    .thr_addr(thr_addr), .thr_data(thr_data), .stage_idx(stage_idx),
    .stage_go(stage_go), .feat_valid(feat_valid), .feat_val(feat_val),
    .feat_last(feat_last), .done(done), .detect(detect),
    .reject_stage(reject_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Threshold ROM with one cycle of read latency.
  int rom [N_STAGES];
  always @(posedge clk) begin
    if (thr_en) thr_data <= W_DATA'(rom[thr_addr]);
  end

  typedef struct packed {
    logic              det;
    logic [W_ADDR-1:0] rej;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tcnt   = 0;

  // Vote plan for the current window.
  int nv [N_STAGES];
  int vv [N_STAGES][MAXV];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  // Reference: sum a stage's votes with clamping, compare with threshold.
  function automatic bit stage_pass(input int s);
    int acc;
    acc = 0;
    for (int j = 0; j < nv[s]; j++) begin
      acc = acc + vv[s][j];
      if (acc > SMAX) acc = SMAX;
      if (acc < SMIN) acc = SMIN;
    end
    return (acc >= rom[s]);
  endfunction

  function automatic res_t model();
    res_t r;
    r.det = 1'b1;
    r.rej = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (!stage_pass(s)) begin
        r.det = 1'b0;
        r.rej = W_ADDR'(s);
        return r;
      end
    end
    return r;
  endfunction

  function automatic void plan_const(input int v);
    for (int s = 0; s < N_STAGES; s++) begin
      nv[s]    = 1;
      vv[s][0] = v;
    end
  endfunction

  function automatic void plan_random();
    for (int s = 0; s < N_STAGES; s++) begin
      nv[s] = int'($urandom_range(MAXV, 1));
      for (int j = 0; j < MAXV; j++) vv[s][j] = int'($urandom_range(700, 0)) - 400;
    end
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("detect", int'(detect), int'(e.det));
          chk("reject_stage", int'(reject_stage), int'(e.rej));
        end
      end
    end
  end

  // Feature engine for stage s, entered in the LOAD cycle; leaves after the
  // cycle following CMP.
  task automatic feed(input int s, input bit noise, input bit gaps,
                      input int abort_stage, output bit aborted);
    aborted = 1'b0;
    if (noise) begin
      feat_valid = 1'b1; feat_val = 16'h8000; feat_last = 1'b1;
    end
    tick();
    for (int j = 0; j < nv[s]; j++) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          feat_valid = 1'b0; feat_last = 1'b0;
          tick();
        end
      end
      feat_valid = 1'b1;
      feat_val   = W_SUM'(vv[s][j]);
      feat_last  = (j == nv[s] - 1);
      if (noise && j == 0) start = 1'b1;
      if (s == abort_stage) begin
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_thr_en", int'(thr_en), 0);
        chk("rst_thr_addr", int'(thr_addr), 0);
        chk("rst_stage_idx", int'(stage_idx), 0);
        chk("rst_stage_go", int'(stage_go), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_detect", int'(detect), 0);
        chk("rst_reject_stage", int'(reject_stage), 0);
        feat_valid = 1'b0; feat_last = 1'b0; start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        aborted = 1'b1;
        return;
      end
      tick();
      start = 1'b0;
    end
    feat_valid = 1'b0; feat_last = 1'b0;
    chk("cmp_busy", int'(busy), 1);
    chk("cmp_done", int'(done), 0);
    if (noise) begin
      feat_valid = 1'b1; feat_val = 16'h8000; feat_last = 1'b1;
    end
    tick();
    feat_valid = 1'b0; feat_last = 1'b0;
    if (stage_pass(s) && s < N_STAGES - 1) begin
      chk("next_thr_en", int'(thr_en), 1);
      chk("next_thr_addr", int'(thr_addr), s + 1);
      chk("next_stage_idx", int'(stage_idx), s + 1);
    end else begin
      chk("done_after_cmp", int'(done), 1);
    end
  endtask

  task automatic run_window(input bit noise, input bit gaps,
                            input int abort_stage, input int exp_lat);
    res_t e;
    int   t0;
    bit   fin;
    bit   aborted;
    e = model();
    if (abort_stage < 0) exp_q.push_back(e);
    if (noise) begin
      feat_valid = 1'b1; feat_val = 16'h4000; feat_last = 1'b1;
      tick();
      feat_valid = 1'b0; feat_last = 1'b0;
    end
    t0    = tcnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_thr_en", int'(thr_en), 1);
    chk("fetch_thr_addr", int'(thr_addr), 0);
    chk("fetch_stage_idx", int'(stage_idx), 0);
    chk("fetch_busy", int'(busy), 1);
    fin     = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (done) begin
        fin = 1'b1;
        if (exp_lat > 0) chk("latency", tcnt - t0, exp_lat);
      end else if (stage_go) begin
        feed(int'(stage_idx), noise, gaps, abort_stage, aborted);
        if (aborted) fin = 1'b1;
      end else begin
        tick();
      end
    end
    if (!fin) chk("window_timeout", 0, 1);
    if (!aborted) begin
      tick();
      tick();
      chk("idle_busy", int'(busy), 0);
      chk("held_detect", int'(detect), int'(e.det));
      chk("held_reject_stage", int'(reject_stage), int'(e.rej));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; feat_valid = 1'b0; feat_val = '0; feat_last = 1'b0;
    rom[0]  = -514;
    rom[24] = -305;
    for (int i = 1; i < N_STAGES - 1; i++) rom[i] = -int'($urandom_range(1000, 0));
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_thr_en", int'(thr_en), 0);
    chk("reset_stage_go", int'(stage_go), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_detect", int'(detect), 0);
    chk("reset_thr_addr", int'(thr_addr), 0);
    chk("reset_stage_idx", int'(stage_idx), 0);
    chk("reset_reject_stage", int'(reject_stage), 0);
    rst = 1'b1;
    tick();

    // Stage-0 reject: -300 + -215 = -515 < -514.
    plan_const(0);
    nv[0] = 2; vv[0][0] = -300; vv[0][1] = -215;
    run_window(1'b0, 1'b0, -1, 0);

    // Equality passes stage 0; stage 1 then rejects.
    plan_const(0);
    nv[0] = 2; vv[0][0] = -300; vv[0][1] = -214;
    vv[1][0] = -2000;
    run_window(1'b0, 1'b0, -1, 0);

    // Full detect, minimum latency.
    plan_const(0);
    run_window(1'b0, 1'b0, -1, 1 + 4 * N_STAGES);

    // Saturation at both ends.
    plan_const(0);
    nv[0] = 2; vv[0][0] = SMAX;  vv[0][1] = 1;
    nv[1] = 2; vv[1][0] = SMIN;  vv[1][1] = -1;
    run_window(1'b0, 1'b0, -1, 0);

    // Protocol noise: start in RUN, feat_valid in IDLE/LOAD/CMP.
    plan_const(0);
    run_window(1'b1, 1'b0, -1, 0);

    // Reset in the middle of stage 7, then a fresh window.
    plan_const(0);
    run_window(1'b0, 1'b0, 7, 0);
    repeat (3) tick();
    plan_random();
    run_window(1'b0, 1'b1, -1, 0);

    // Randomised windows.
    for (int w = 0; w < 10; w++) begin
      plan_random();
      run_window(bit'($urandom_range(1, 0)), 1'b1, -1, 0);
    end

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
